mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single shared main-memory port behind the direct-mapped instruction and data caches.
- The I-side (fetch-stage cache miss/fill, read-only) and the D-side (memory-stage cache miss/fill or write-back, read/write) each present a hold-until-done request.
- The arbiter grants one requester at a time with round-robin fairness and drives the memory port for that transaction.
- It returns data, a done pulse and an error flag, and enforces a watchdog timeout on the memory.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 16, maximum BUSY cycles waiting for mem_done before forced completion with error (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  1  I-side read request; held high until i_done is sampled.
- i_addr  input  ADDR_W  I-side address; stable while i_req is high.
- i_done  output  1  one-cycle completion pulse for the I-side.
- i_rdata  output  DATA_W  I-side read data; valid only while i_done is high.
- i_err  output  1  I-side error; valid only while i_done is high.
- i_stall  output  1  i_req & ~i_done.
- d_req  input  1  D-side request; held high until d_done is sampled.
- d_wr  input  1  D-side write (1) or read (0); stable while d_req is high.
- d_addr  input  ADDR_W  D-side address.
- d_wdata  input  DATA_W  D-side write data.
- d_done  output  1  one-cycle completion pulse for the D-side.
- d_rdata  output  DATA_W  D-side read data; valid only while d_done is high.
- d_err  output  1  D-side error; valid only while d_done is high.
- d_stall  output  1  d_req & ~d_done.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid while mem_done is high.
- mem_done  input  1  memory completion for the current command.
- mem_err  input  1  memory error; qualified by mem_done.
- busy  output  1  high whenever state != IDLE.

Behaviour:

States:
- IDLE, BUSY_I, BUSY_D.
- Registered state, last_grant (0 = I, 1 = D), cmd_addr, cmd_wdata, cmd_wr, and an 8-bit wait counter.

Reset (asynchronous, takes effect immediately, also mid-transaction):
- state = IDLE, last_grant = 1 (so the I-side wins the first tie), counter = 0, cmd registers = 0.
- All outputs are 0, including mem_rd and mem_wr in the same cycle. An aborted transaction never produces a done pulse.

IDLE:
- Only i_req: go to BUSY_I.
- Only d_req: go to BUSY_D.
- Both: grant the side != last_grant.
- On grant, latch address, wdata and wr from the winner; set last_grant = winner; clear the counter.
- No mem strobes are asserted in IDLE.

BUSY_x (strobes):
- mem_rd = ~cmd_wr and mem_wr = cmd_wr, held every cycle.
- mem_addr and mem_wdata come from the cmd registers and are never taken from live inputs.

BUSY_x (completion):
- In any cycle with mem_done = 1: x_done = 1 combinationally; x_rdata = mem_rdata (0 on writes); x_err = mem_err. Next state is IDLE.
- Otherwise the counter increments. If the counter equals TIMEOUT-1 and mem_done = 0, force completion that cycle: x_done = 1, x_err = 1, x_rdata = 0, next state IDLE.

Latency and ordering rules:
- Minimum request-to-done latency is 2 cycles: request seen in IDLE, then mem_done in the first BUSY cycle.
- An IDLE cycle always separates two transactions; there are no back-to-back grants.
- Requests arriving during BUSY wait; their stall stays high.
- A requester that drops req before its done pulse is a protocol error. The arbiter ignores it and completes the transaction anyway.
- i_done and d_done are never high in the same cycle.
- i_rdata and d_rdata are 0 when their done is low.
- mem_done seen in IDLE is ignored.
- Round-robin guarantees each side waits at most one other transaction under continuous contention.

Test Plan:
- Reset, then i_req with i_addr=0x0040, mem_done on the 1st BUSY cycle with mem_rdata=0xA5A5 -> mem_rd=1 and mem_addr=0x0040 in cycle 1; i_done=1 and i_rdata=0xA5A5 in cycle 1; busy low in cycle 2.
- i_req and d_req (write, 0x0100/0x1234) asserted together from reset, memory latency 4 -> I granted first. Then IDLE, then D granted with mem_wr=1, mem_wdata=0x1234. A third tie grants I again.
- Both sides held continuously for 6 transactions -> grants alternate I,D,I,D,I,D. Neither stall is high for more than 2×(latency+1) cycles.
- d_req read, mem_done never asserted, TIMEOUT=16 -> d_done=1, d_err=1, d_rdata=0 on the 16th BUSY cycle; arbiter is back in IDLE next cycle.
- rst pulsed during BUSY_D in the 2nd BUSY cycle -> mem_rd/mem_wr drop in the same cycle; no d_done; after release, the held d_req is re-granted from IDLE.
- mem_done=1 with mem_err=1 on an I read -> i_done=1, i_err=1, i_rdata=mem_rdata in that cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter.
// The arbiter connects through 'slave'; caches and memory connect through 'master'.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_done;
   logic [DATA_W-1:0] i_rdata;
   logic              i_err;
   logic              i_stall;

   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;
   logic              d_stall;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              mem_err;

   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
             mem_rdata, mem_done, mem_err,
      output i_done, i_rdata, i_err, i_stall,
             d_done, d_rdata, d_err, d_stall,
             mem_rd, mem_wr, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
             mem_rdata, mem_done, mem_err,
      input  i_done, i_rdata, i_err, i_stall,
             d_done, d_rdata, d_err, d_stall,
             mem_rd, mem_wr, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache for one shared memory port,
// with a watchdog that force-completes a stuck transaction with an error.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   logic [1:0]        state;
   logic              last_grant;
   cmd_t              cmd;
   logic [7:0]        wait_cnt;

   logic              grant_i, grant_d;
   logic              in_busy, timeout, finish;
   logic [DATA_W-1:0] rdata;
   logic              err;

   // On a tie the side that did not win last time gets the port.
   assign grant_i = bus.i_req & (~bus.d_req | last_grant);
   assign grant_d = bus.d_req & (~bus.i_req | ~last_grant);

   assign in_busy = (state == BUSY_I) | (state == BUSY_D);
   assign timeout = in_busy & ~bus.mem_done & (wait_cnt == WAIT_LAST);
   assign finish  = in_busy & (bus.mem_done | timeout);

   // Timeout completions carry no data and always flag an error.
   assign rdata = (bus.mem_done & ~cmd.wr) ? bus.mem_rdata : '0;
   assign err   = bus.mem_done ? bus.mem_err : 1'b1;

   assign bus.i_done  = finish & (state == BUSY_I);
   assign bus.d_done  = finish & (state == BUSY_D);
   assign bus.i_rdata = bus.i_done ? rdata : '0;
   assign bus.d_rdata = bus.d_done ? rdata : '0;
   assign bus.i_err   = bus.i_done & err;
   assign bus.d_err   = bus.d_done & err;

   // Stalls are forced low while reset is held so every output reads zero.
   assign bus.i_stall = bus.i_req & ~bus.i_done & ~rst;
   assign bus.d_stall = bus.d_req & ~bus.d_done & ~rst;

   assign bus.mem_rd    = in_busy & ~cmd.wr;
   assign bus.mem_wr    = in_busy & cmd.wr;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;
   assign bus.busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cmd        <= '0;
         wait_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state      <= BUSY_I;
                  last_grant <= 1'b0;
                  cmd        <= '{wr: 1'b0, addr: bus.i_addr, wdata: '0};
                  wait_cnt   <= '0;
               end else if (grant_d) begin
                  state      <= BUSY_D;
                  last_grant <= 1'b1;
                  cmd        <= '{wr: bus.d_wr, addr: bus.d_addr, wdata: bus.d_wdata};
                  wait_cnt   <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (finish) state <= IDLE;
               else        wait_cnt <= wait_cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge and
// outputs are checked 2 ns later, well before the next rising edge.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Longest run of consecutive stall cycles per side while enabled.
   bit mon_en = 1'b0;
   int run_i = 0, run_d = 0, max_i = 0, max_d = 0;
   always @(negedge clk) begin
      #3;
      if (mon_en) begin
         run_i = bus.i_stall ? run_i + 1 : 0;
         run_d = bus.d_stall ? run_d + 1 : 0;
         if (run_i > max_i) max_i = run_i;
         if (run_d > max_d) max_d = run_d;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Assert rst now, release it at the next falling edge; ends in an IDLE cycle.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
   endtask

   // Called from an IDLE cycle in which the given side will be granted.
   // Memory answers on BUSY cycle 'lat'; returns in the following IDLE cycle.
   task automatic xact(input bit side_d, input int lat, input logic [15:0] rd,
                       input bit merr, input logic [15:0] addr, input bit wr,
                       input logic [15:0] wd);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         bus.mem_done  = (k == lat - 1);
         bus.mem_rdata = rd;
         bus.mem_err   = merr;
         #2;
         chk("mem_rd", bus.mem_rd, !wr);
         chk("mem_wr", bus.mem_wr, wr);
         chk("mem_addr", bus.mem_addr, addr);
         if (wr) chk("mem_wdata", bus.mem_wdata, wd);
         chk("i_done", bus.i_done, !side_d && (k == lat - 1));
         chk("d_done", bus.d_done, side_d && (k == lat - 1));
         if (k == lat - 1) begin
            if (side_d) begin
               chk("d_rdata", bus.d_rdata, wr ? 16'h0 : rd);
               chk("d_err", bus.d_err, merr);
               chk("i_rdata_idle", bus.i_rdata, 0);
            end else begin
               chk("i_rdata", bus.i_rdata, rd);
               chk("i_err", bus.i_err, merr);
               chk("d_rdata_idle", bus.d_rdata, 0);
            end
         end
      end
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.mem_err  = 1'b0;
      #2;
      chk("busy_after", bus.busy, 0);
   endtask

   initial begin
      bus.i_req = 0; bus.i_addr = 0;
      bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
      bus.mem_rdata = 0; bus.mem_done = 0; bus.mem_err = 0;

      // Reset state, with a request already pending.
      bus.i_req = 1; bus.i_addr = 16'h0040;
      @(negedge clk); #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_i_stall", bus.i_stall, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      rst = 0;
      #1;
      chk("idle_i_stall", bus.i_stall, 1);

      // Single I read, memory answers in the first BUSY cycle.
      xact(0, 1, 16'hA5A5, 0, 16'h0040, 0, 16'h0);
      bus.i_req = 0;

      // mem_done while IDLE is ignored.
      bus.mem_done = 1; bus.mem_rdata = 16'hFFFF;
      #1;
      chk("idle_md_i_done", bus.i_done, 0);
      chk("idle_md_d_done", bus.d_done, 0);
      @(negedge clk); #2;
      chk("idle_md_busy", bus.busy, 0);
      bus.mem_done = 0;

      // Tie from reset: I, then D write, then I again.
      bus.i_req = 1; bus.i_addr = 16'h0200;
      bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
      do_reset();
      chk("tie_i_stall", bus.i_stall, 1);
      chk("tie_d_stall", bus.d_stall, 1);
      xact(0, 4, 16'h1111, 0, 16'h0200, 0, 16'h0);
      xact(1, 4, 16'h2222, 0, 16'h0100, 1, 16'h1234);
      xact(0, 4, 16'h3333, 0, 16'h0200, 0, 16'h0);

      // Continuous contention, latency 3: I,D,I,D,I,D.
      bus.d_wr = 0; bus.d_addr = 16'h0180;
      do_reset();
      mon_en = 1;
      for (int n = 0; n < 3; n++) begin
         xact(0, 3, 16'h4000 + 16'(n), 0, 16'h0200, 0, 16'h0);
         xact(1, 3, 16'h5000 + 16'(n), 0, 16'h0180, 0, 16'h0);
      end
      bus.i_req = 0; bus.d_req = 0;
      @(negedge clk); #4;
      mon_en = 0;
      chk("max_i_stall_le_8", 32'(max_i <= 8), 1);
      chk("max_d_stall_le_8", 32'(max_d <= 8), 1);
      chk("max_d_stall_seen", 32'(max_d >= 3), 1);

      // Watchdog: D read, memory never answers.
      bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0300;
      bus.mem_rdata = 16'hDEAD;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #2;
         chk("to_mem_rd", bus.mem_rd, 1);
         chk("to_d_done", bus.d_done, (k == 15));
         if (k == 15) begin
            chk("to_d_err", bus.d_err, 1);
            chk("to_d_rdata", bus.d_rdata, 0);
         end
      end
      @(negedge clk);
      bus.d_req = 0;
      #2;
      chk("to_idle", bus.busy, 0);

      // Reset in the second BUSY_D cycle, then re-grant of the held request.
      bus.d_req = 1; bus.d_addr = 16'h0310;
      @(negedge clk); #2;
      chk("ab_busy1", bus.busy, 1);
      @(negedge clk); #2;
      chk("ab_mem_rd_before", bus.mem_rd, 1);
      bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
      rst = 1;
      #1;
      chk("ab_mem_rd", bus.mem_rd, 0);
      chk("ab_mem_wr", bus.mem_wr, 0);
      chk("ab_d_done", bus.d_done, 0);
      chk("ab_d_stall", bus.d_stall, 0);
      chk("ab_busy", bus.busy, 0);
      @(negedge clk);
      rst = 0; bus.mem_done = 0;
      #2;
      chk("ab_idle_stall", bus.d_stall, 1);
      xact(1, 2, 16'h7777, 0, 16'h0310, 0, 16'h0);
      bus.d_req = 0;

      // Memory error on an I read.
      bus.i_req = 1; bus.i_addr = 16'h0050;
      xact(0, 2, 16'h3C3C, 1, 16'h0050, 0, 16'h0);
      bus.i_req = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
